ahbl_arbiter2: RTL and testbench
================================

Name: ahbl_arbiter2

Overview:
- Two-master AHB-Lite arbiter that shares the single system bus (splitter plus all slaves) between master M0 (Hazard2 CPU) and master M1 (a bus master such as an I2S-to-DMEM DMA engine).
- Sits between the masters and the existing splitter.
- Ownership changes only at IDLE boundaries, so no transfer is ever split or replayed.
- Provides per-master saturating wait-cycle counters for profiling.

Parameters:
- PARK_MASTER, 0: address-phase owner after reset and while both masters are idle at reset.
- WCNT_W, 16: width of the wait-cycle counters.

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- M0_HADDR, M1_HADDR  in  32  master address.
- M0_HTRANS, M1_HTRANS  in  2  master transfer type; only bit 1 is examined (1 = NONSEQ/SEQ).
- M0_HSIZE, M1_HSIZE  in  3  master transfer size.
- M0_HWRITE, M1_HWRITE  in  1  master write flag.
- M0_HWDATA, M1_HWDATA  in  32  master write data.
- M0_HREADY, M1_HREADY  out  1  per-master ready.
- M0_HRDATA, M1_HRDATA  out  32  read data; both are the bus HRDATA, broadcast.
- HADDR, HTRANS, HSIZE, HWRITE, HWDATA  out  32/2/3/1/32  shared bus to the splitter and slaves.
- HREADY  in  1  shared bus ready, taken from the splitter.
- HRDATA  in  32  shared bus read data.
- GRANT  out  1  current address-phase owner.
- M0_WAIT, M1_WAIT  out  WCNT_W  saturating count of cycles that master was stalled by arbitration.

Behaviour:
- State registers:
  - aown: address-phase owner.
  - down / dval: data-phase owner and valid flag.
  - M0_WAIT, M1_WAIT.
- Reset (HRESET=1 at a clock edge):
  - aown=PARK_MASTER, dval=0, both wait counters 0.
  - GRANT=PARK_MASTER.
  - Bus address outputs are driven by the parked master.
- Reset mid-transfer discards ownership; no transfer completion is signalled afterwards.
- Address-phase mux (combinational): HADDR, HTRANS, HSIZE and HWRITE come from master aown.
- Data-phase mux: HWDATA comes from master down when dval=1, else from M0.
- Ready to each master m:
  - m==aown: Mm_HREADY = HREADY.
  - m!=aown: Mm_HREADY = ~Mm_HTRANS[1] (an idle non-owner sees 1; a requesting non-owner is stalled and must hold its address/control, per AHB-Lite).
- Data-phase tracking, on each edge with HREADY=1:
  - dval <= HTRANS[1] of the bus.
  - down <= aown.
- Handover rule, evaluated each edge with HREADY=1:
  - Condition: owner's HTRANS[1]=0 AND other master's HTRANS[1]=1.
  - Result: aown <= other.
  - In all other cases aown holds; there is no handover while HREADY=0.
- Handover latency and bus behaviour:
  - The bus carries the old owner's IDLE for exactly one cycle.
  - The new owner's address appears the cycle after the handover edge.
  - The old owner's last data phase has completed, because the handover requires HREADY=1, so no read data is lost.
- A master issuing back-to-back NONSEQ keeps the bus indefinitely; fairness depends on masters inserting IDLE. Hazard2 idles between non-sequential fetch gaps.
- Simultaneous requests after both masters were idle: the current aown keeps the bus (no switch, zero latency). The other master waits for the next IDLE boundary.
- Wait counters: Mm_WAIT increments each cycle where m!=aown and Mm_HTRANS[1]=1. It saturates at all-ones and does not wrap.
- GRANT = aown (registered).

Test Plan:
- Reset with PARK_MASTER=0, then M0 reads 0x0000_0010 → bus HADDR=0x0000_0010 in the same cycle; M0_HRDATA equals the slave data one cycle later; GRANT=0; M1_WAIT=0.
- M0 idle, M1 writes 0x2000_0004 with data 0xCAFEF00D → cycle 0: bus HTRANS=IDLE, M1_HREADY=0. Edge: GRANT=1. Cycle 1: HADDR=0x2000_0004. Cycle 2: HWDATA=0xCAFEF00D. M1_WAIT=1.
- M0 issues four back-to-back NONSEQ while M1 requests → M1_HREADY=0 for all four, then GRANT switches only after M0 drives IDLE. M1_WAIT=5.
- Slave inserts 3 wait states on M0's last transfer while M0 goes IDLE and M1 requests → aown stays 0 until HREADY=1, and the M0 read data is delivered intact.
- Force M1 to request continuously for 70000 cycles with M0 never idle, at WCNT_W=16 → M1_WAIT saturates at 0xFFFF.
- Assert HRESET during an M1-owned data phase → the next cycle has GRANT=PARK_MASTER, dval=0, and both counters at 0.

Source files
------------

// File: rtl/ahbl_arbiter2.sv
// Two-master AHB-Lite arbiter in front of the splitter.
// Ownership moves only at IDLE boundaries; per-master wait counters.
module ahbl_arbiter2 #(
  parameter int PARK_MASTER = 0,
  parameter int WCNT_W      = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [31:0]       M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic [2:0]        M0_HSIZE,
  input  logic              M0_HWRITE,
  input  logic [31:0]       M0_HWDATA,
  output logic              M0_HREADY,
  output logic [31:0]       M0_HRDATA,
  input  logic [31:0]       M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic [2:0]        M1_HSIZE,
  input  logic              M1_HWRITE,
  input  logic [31:0]       M1_HWDATA,
  output logic              M1_HREADY,
  output logic [31:0]       M1_HRDATA,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic [31:0]       HRDATA,
  output logic              GRANT,
  output logic [WCNT_W-1:0] M0_WAIT,
  output logic [WCNT_W-1:0] M1_WAIT
);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } own_t;

  localparam own_t PARK = own_t'(PARK_MASTER[0]);

  own_t              aown, aown_n;
  own_t              down, down_n;
  logic              dval, dval_n;
  logic [WCNT_W-1:0] m0_wait_n, m1_wait_n;

  logic req0, req1, own_req, oth_req;

  logic unused_ok;
  assign unused_ok = ^{M0_HTRANS[0], M1_HTRANS[0]};

  assign req0 = M0_HTRANS[1];
  assign req1 = M1_HTRANS[1];

  assign own_req = (aown == OWN_M1) ? req1 : req0;
  assign oth_req = (aown == OWN_M1) ? req0 : req1;

  always_comb begin
    HADDR  = M0_HADDR;
    HTRANS = M0_HTRANS;
    HSIZE  = M0_HSIZE;
    HWRITE = M0_HWRITE;
    if (aown == OWN_M1) begin
      HADDR  = M1_HADDR;
      HTRANS = M1_HTRANS;
      HSIZE  = M1_HSIZE;
      HWRITE = M1_HWRITE;
    end
  end

  assign HWDATA = (dval && down == OWN_M1) ? M1_HWDATA : M0_HWDATA;

  // A requesting non-owner is stalled until it is handed the bus
  assign M0_HREADY = (aown == OWN_M0) ? HREADY : ~req0;
  assign M1_HREADY = (aown == OWN_M1) ? HREADY : ~req1;

  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

  assign GRANT = aown;

  always_comb begin
    aown_n    = aown;
    down_n    = down;
    dval_n    = dval;
    m0_wait_n = M0_WAIT;
    m1_wait_n = M1_WAIT;
    if (HREADY) begin
      dval_n = HTRANS[1];
      down_n = aown;
      if (!own_req && oth_req)
        aown_n = own_t'(~aown);
    end
    if (aown != OWN_M0 && req0 && M0_WAIT != '1)
      m0_wait_n = M0_WAIT + WCNT_W'(1);
    if (aown != OWN_M1 && req1 && M1_WAIT != '1)
      m1_wait_n = M1_WAIT + WCNT_W'(1);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      aown    <= PARK;
      down    <= PARK;
      dval    <= 1'b0;
      M0_WAIT <= '0;
      M1_WAIT <= '0;
    end else begin
      aown    <= aown_n;
      down    <= down_n;
      dval    <= dval_n;
      M0_WAIT <= m0_wait_n;
      M1_WAIT <= m1_wait_n;
    end
  end

endmodule

// File: tb/tb_ahbl_arbiter2.sv
// Directed bench for ahbl_arbiter2: handover, stalls,
// wait-state hold, counter saturation and reset.
module tb_ahbl_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [2:0]  m0_hsize, m1_hsize;
  logic        m0_hwrite, m1_hwrite;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hready, m1_hready;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        grant;
  logic [15:0] m0_wait, m1_wait;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ahbl_arbiter2 #(.PARK_MASTER(0), .WCNT_W(16)) dut (
    .HCLK(clk), .HRESET(rst),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans),
    .M0_HSIZE(m0_hsize), .M0_HWRITE(m0_hwrite),
    .M0_HWDATA(m0_hwdata), .M0_HREADY(m0_hready),
    .M0_HRDATA(m0_hrdata),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans),
    .M1_HSIZE(m1_hsize), .M1_HWRITE(m1_hwrite),
    .M1_HWDATA(m1_hwdata), .M1_HREADY(m1_hready),
    .M1_HRDATA(m1_hrdata),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata),
    .HREADY(hready), .HRDATA(hrdata),
    .GRANT(grant), .M0_WAIT(m0_wait), .M1_WAIT(m1_wait)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_htrans = 2'b00;
    m1_htrans = 2'b00;
    m0_hwrite = 1'b0;
    m1_hwrite = 1'b0;
    m0_hsize  = 3'd2;
    m1_hsize  = 3'd2;
    m0_haddr  = 32'h0;
    m1_haddr  = 32'h0;
    m0_hwdata = 32'h1111_1111;
    m1_hwdata = 32'h2222_2222;
    hready    = 1'b1;
    hrdata    = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    do_reset();

    // reset state and a plain M0 read
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_m0wait", m0_wait, 0);
    chk("rst_m1wait", m1_wait, 0);
    chk("rst_hwdata", hwdata, 32'h1111_1111);
    m0_htrans = 2'b10;
    m0_haddr  = 32'h0000_0010;
    #1;
    chk("m0rd_haddr", haddr, 32'h0000_0010);
    chk("m0rd_hready", m0_hready, 1);
    cyc();
    m0_htrans = 2'b00;
    hrdata    = 32'hDEAD_BEEF;
    #1;
    chk("m0rd_rdata", m0_hrdata, 32'hDEAD_BEEF);
    chk("m1_rdata_bcast", m1_hrdata, 32'hDEAD_BEEF);
    chk("m0rd_grant", grant, 0);
    chk("m0rd_m1wait", m1_wait, 0);

    // M1 write while M0 idle
    do_reset();
    m1_htrans = 2'b10;
    m1_haddr  = 32'h2000_0004;
    m1_hwrite = 1'b1;
    #1;
    chk("m1wr_c0_htrans", htrans, 0);
    chk("m1wr_c0_m1rdy", m1_hready, 0);
    chk("m1wr_c0_m0rdy", m0_hready, 1);
    cyc();
    chk("m1wr_grant", grant, 1);
    chk("m1wr_c1_haddr", haddr, 32'h2000_0004);
    chk("m1wr_c1_htrans", htrans, 2);
    chk("m1wr_c1_hwrite", hwrite, 1);
    chk("m1wr_c1_m1rdy", m1_hready, 1);
    cyc();
    m1_htrans = 2'b00;
    m1_hwdata = 32'hCAFE_F00D;
    #1;
    chk("m1wr_c2_hwdata", hwdata, 32'hCAFE_F00D);
    chk("m1wr_m1wait", m1_wait, 1);
    chk("m1wr_c2_grant", grant, 1);

    // M0 back-to-back NONSEQ holds off M1
    do_reset();
    m1_htrans = 2'b10;
    m1_haddr  = 32'h2000_0100;
    for (int i = 0; i < 4; i++) begin
      m0_htrans = 2'b10;
      m0_haddr  = 32'h100 + 32'(4 * i);
      #1;
      chk("b2b_m1rdy", m1_hready, 0);
      chk("b2b_grant", grant, 0);
      chk("b2b_haddr", haddr, 32'h100 + 32'(4 * i));
      cyc();
    end
    m0_htrans = 2'b00;
    #1;
    chk("b2b_idle_grant", grant, 0);
    chk("b2b_idle_htrans", htrans, 0);
    chk("b2b_idle_m1rdy", m1_hready, 0);
    cyc();
    chk("b2b_sw_grant", grant, 1);
    chk("b2b_m1wait", m1_wait, 5);
    chk("b2b_sw_haddr", haddr, 32'h2000_0100);
    chk("b2b_sw_m1rdy", m1_hready, 1);

    // slave wait states block handover
    do_reset();
    m0_htrans = 2'b10;
    m0_haddr  = 32'h0000_0040;
    cyc();
    m0_htrans = 2'b00;
    m1_htrans = 2'b10;
    m1_haddr  = 32'h2000_0008;
    hready    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_grant", grant, 0);
      chk("ws_m0rdy", m0_hready, 0);
      chk("ws_m1rdy", m1_hready, 0);
      cyc();
    end
    hready = 1'b1;
    hrdata = 32'h5A5A_A5A5;
    #1;
    chk("ws_rdata", m0_hrdata, 32'h5A5A_A5A5);
    chk("ws_done_m0rdy", m0_hready, 1);
    chk("ws_done_grant", grant, 0);
    cyc();
    chk("ws_sw_grant", grant, 1);
    chk("ws_m1wait", m1_wait, 4);

    // wait counter saturation
    do_reset();
    m0_htrans = 2'b10;
    m1_htrans = 2'b10;
    repeat (65534) cyc();
    chk("sat_pre", m1_wait, 16'hFFFE);
    cyc();
    chk("sat_hit", m1_wait, 16'hFFFF);
    repeat (4465) cyc();
    chk("sat_hold", m1_wait, 16'hFFFF);
    chk("sat_grant", grant, 0);
    chk("sat_m0wait", m0_wait, 0);

    // reset during an M1 data phase
    do_reset();
    m1_htrans = 2'b10;
    m1_haddr  = 32'h2000_0010;
    cyc();
    m0_htrans = 2'b10;
    cyc();
    chk("mid_grant", grant, 1);
    chk("mid_hwdata", hwdata, 32'h2222_2222);
    chk("mid_m0wait", m0_wait, 1);
    chk("mid_m1wait", m1_wait, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle_all();
    #1;
    chk("mrst_grant", grant, 0);
    chk("mrst_hwdata", hwdata, 32'h1111_1111);
    chk("mrst_m0wait", m0_wait, 0);
    chk("mrst_m1wait", m1_wait, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
